ika2151_timerbank: RTL

IKA2151_TIMERBANK -- requirements
Module: ika2151_timerbank

---
 rtl/ika2151_pkg.sv | 17 +
 rtl/ika2151_timerbank_ch.sv | 132 +++++++++++++
 rtl/ika2151_timerbank.sv | 70 +++++++
 3 files changed

// File: rtl/ika2151_pkg.sv
// Shared definitions for the IKA2151 timer bank: parameter defaults,
// per-channel FSM state encoding and TEST register bit positions.
package ika2151_pkg;

    localparam int NUM_TIMERS_DEF   = 2;
    localparam int CNT_WIDTH_DEF    = 10;
    localparam int PRESCALE_DIV_DEF = 16;

    // TEST register bit that turns every phi1 step into a sample tick
    localparam int TEST_TICK_BIT = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } tmr_state_t;

endpackage

// File: rtl/ika2151_timerbank_ch.sv
// One timer channel: run-edge start, optional slow prescaler, up-counter
// with reload on overflow, one-step overflow pulse and sticky status flag.
module ika2151_timerbank_ch
    import ika2151_pkg::*;
#(
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF,
    parameter int PRESCALE_DIV = PRESCALE_DIV_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step,
    input  logic                 sample_tick,
    input  logic [CNT_WIDTH-1:0] load,
    input  logic                 run,
    input  logic                 oneshot,
    input  logic                 prescale_sel,
    input  logic                 irq_en,
    input  logic                 frst,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 ovfl,
    output logic                 flag
);

    localparam int PSC_W = $clog2(PRESCALE_DIV);

    tmr_state_t           state_r;
    tmr_state_t           state_next_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_next_s;
    logic [PSC_W-1:0]     psc_r;
    logic [PSC_W-1:0]     psc_next_s;
    logic                 run_prev_r;
    logic                 ovfl_r;
    logic                 flag_r;
    logic                 flag_next_s;
    logic                 run_rise_s;
    logic                 ch_tick_s;
    logic                 overflow_s;

    assign run_rise_s = run & ~run_prev_r;
    // slow channels only advance when the prescaler is about to wrap
    assign ch_tick_s  = sample_tick & (~prescale_sel | (&psc_r));
    // a falling RUN wins over a coincident tick, so no overflow then
    assign overflow_s = (state_r == ST_COUNT) & run & ch_tick_s & (&cnt_r);

    // State and datapath registers; only phi1 steps advance them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_WIDTH{1'b0}};
            psc_r      <= {PSC_W{1'b0}};
            run_prev_r <= 1'b0;
            ovfl_r     <= 1'b0;
            flag_r     <= 1'b0;
        end else if (step) begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            psc_r      <= psc_next_s;
            run_prev_r <= run;
            ovfl_r     <= overflow_s;
            flag_r     <= flag_next_s;
        end else begin
            state_r    <= state_r;
            cnt_r      <= cnt_r;
            psc_r      <= psc_r;
            run_prev_r <= run_prev_r;
            ovfl_r     <= ovfl_r;
            flag_r     <= flag_r;
        end
    end

    // Next-state: start on RUN rising edge, stop on RUN low or one-shot overflow
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run_rise_s) state_next_s = ST_COUNT;
                else            state_next_s = ST_IDLE;
            end
            ST_COUNT: begin
                if (!run)                      state_next_s = ST_IDLE;
                else if (overflow_s && oneshot) state_next_s = ST_IDLE;
                else                           state_next_s = ST_COUNT;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath next values: load on start, count/reload while counting, flag update
    always_comb begin
        cnt_next_s = cnt_r;
        psc_next_s = psc_r;
        case (state_r)
            ST_IDLE: begin
                if (run_rise_s) begin
                    cnt_next_s = load;
                    psc_next_s = {PSC_W{1'b0}};
                end else begin
                    cnt_next_s = cnt_r;
                    psc_next_s = psc_r;
                end
            end
            ST_COUNT: begin
                if (run) begin
                    if (sample_tick) psc_next_s = psc_r + {{(PSC_W-1){1'b0}}, 1'b1};
                    else             psc_next_s = psc_r;
                    if (overflow_s)     cnt_next_s = load;
                    else if (ch_tick_s) cnt_next_s = cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    else                cnt_next_s = cnt_r;
                end else begin
                    cnt_next_s = cnt_r;
                    psc_next_s = psc_r;
                end
            end
            default: begin
                cnt_next_s = cnt_r;
                psc_next_s = psc_r;
            end
        endcase

        // setting beats a simultaneous clear so no overflow event is lost
        flag_next_s = flag_r;
        if (overflow_s && irq_en) flag_next_s = 1'b1;
        else if (frst)            flag_next_s = 1'b0;
        else                      flag_next_s = flag_r;
    end

    assign cnt  = cnt_r;
    assign ovfl = ovfl_r;
    assign flag = flag_r;

endmodule

// File: rtl/ika2151_timerbank.sv
// IKA2151 timer bank top: derives the phi1 step and sample tick, replicates
// the timer channel and reduces the status flags into the interrupt line.
module ika2151_timerbank
    import ika2151_pkg::*;
#(
    parameter int NUM_TIMERS   = NUM_TIMERS_DEF,
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF,
    parameter int PRESCALE_DIV = PRESCALE_DIV_DEF
) (
    input  logic                            i_EMUCLK,
    input  logic                            i_MRST_n,
    input  logic                            i_phi1_PCEN_n,
    input  logic                            i_phi1_NCEN_n,
    input  logic                            i_CYCLE_31,
    input  logic [7:0]                      i_TEST,
    input  logic [NUM_TIMERS*CNT_WIDTH-1:0] i_LOAD,
    input  logic [NUM_TIMERS-1:0]           i_RUN,
    input  logic [NUM_TIMERS-1:0]           i_ONESHOT,
    input  logic [NUM_TIMERS-1:0]           i_PRESCALE_SEL,
    input  logic [NUM_TIMERS-1:0]           i_IRQ_EN,
    input  logic [NUM_TIMERS-1:0]           i_FRST,
    output logic [NUM_TIMERS*CNT_WIDTH-1:0] o_CNT,
    output logic [NUM_TIMERS-1:0]           o_OVFL,
    output logic [NUM_TIMERS-1:0]           o_FLAG,
    output logic                            o_IRQ_n
);

    logic                  step_s;
    logic                  sample_tick_s;
    logic [NUM_TIMERS-1:0] flag_s;
    logic                  irq_n_r;
    logic                  unused_s;

    assign step_s        = ~i_phi1_NCEN_n;
    assign sample_tick_s = i_CYCLE_31 | i_TEST[TEST_TICK_BIT];
    // positive phase enable and remaining TEST bits have no role in this block
    assign unused_s      = ^{i_phi1_PCEN_n, i_TEST[7:3], i_TEST[1:0]};

    for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_ch
        ika2151_timerbank_ch #(
            .CNT_WIDTH    (CNT_WIDTH),
            .PRESCALE_DIV (PRESCALE_DIV)
        ) u_ch (
            .clk          (i_EMUCLK),
            .rst_n        (i_MRST_n),
            .step         (step_s),
            .sample_tick  (sample_tick_s),
            .load         (i_LOAD[k*CNT_WIDTH +: CNT_WIDTH]),
            .run          (i_RUN[k]),
            .oneshot      (i_ONESHOT[k]),
            .prescale_sel (i_PRESCALE_SEL[k]),
            .irq_en       (i_IRQ_EN[k]),
            .frst         (i_FRST[k]),
            .cnt          (o_CNT[k*CNT_WIDTH +: CNT_WIDTH]),
            .ovfl         (o_OVFL[k]),
            .flag         (flag_s[k])
        );
    end

    // Interrupt line: registered NOR of all flags, one phi1 step behind them
    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n)   irq_n_r <= 1'b1;
        else if (step_s) irq_n_r <= ~(|flag_s);
        else             irq_n_r <= irq_n_r;
    end

    assign o_FLAG  = flag_s;
    assign o_IRQ_n = irq_n_r;

endmodule
